// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: reset vector default, decoder
// op_type encodings and the fetch FSM state encodings.
package fetch_unit_pkg;

    localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFC;

    // Decoder op_type encodings (operand-shape classes)
    localparam logic [4:0] OP_IMP = 5'd0;   // implied / accumulator
    localparam logic [4:0] OP_IMM = 5'd1;   // immediate
    localparam logic [4:0] OP_ZPG = 5'd2;   // zero page (any index)
    localparam logic [4:0] OP_ABS = 5'd3;   // absolute
    localparam logic [4:0] OP_JSR = 5'd4;
    localparam logic [4:0] OP_JUM = 5'd5;   // JMP abs
    localparam logic [4:0] OP_JIN = 5'd6;   // JMP (ind)
    localparam logic [4:0] OP_AXY = 5'd7;   // absolute,X / absolute,Y
    localparam logic [4:0] OP_RTI = 5'd8;
    localparam logic [4:0] OP_RTS = 5'd9;
    localparam logic [4:0] OP_JAM = 5'd10;
    localparam logic [4:0] OP_REL = 5'd11;  // branches
    localparam logic [4:0] OP_IZX = 5'd12;  // (zp,X)
    localparam logic [4:0] OP_IZY = 5'd13;  // (zp),Y

    typedef logic [3:0] fetch_state_t;

    localparam fetch_state_t VEC_LO   = 4'd0;
    localparam fetch_state_t VEC_HI   = 4'd1;
    localparam fetch_state_t ISSUE_OP = 4'd2;
    localparam fetch_state_t CAP_OP   = 4'd3;
    localparam fetch_state_t ISSUE_B1 = 4'd4;
    localparam fetch_state_t CAP_B1   = 4'd5;
    localparam fetch_state_t ISSUE_B2 = 4'd6;
    localparam fetch_state_t CAP_B2   = 4'd7;
    localparam fetch_state_t VALID    = 4'd8;
    localparam fetch_state_t JAM      = 4'd9;

endpackage

// File: rtl/fetch_unit_instr_len.sv
// Instruction length classification from decoder outputs. Shared with the
// execute sequencer, which needs the same length for PC-relative maths.
module instr_len
    import fetch_unit_pkg::*;
(
    input  logic [4:0] op_type,
    input  logic       single_byte,
    output logic [1:0] len,
    output logic       is_jam
);

    // Length decode; JAM reports length 1 but is flagged separately.
    always_comb begin
        is_jam = (op_type == OP_JAM);
        len    = 2'd2;
        if (is_jam || single_byte || op_type == OP_RTI || op_type == OP_RTS) begin
            len = 2'd1;
        end else if (op_type == OP_JSR || op_type == OP_ABS || op_type == OP_JUM ||
                     op_type == OP_JIN || op_type == OP_AXY) begin
            len = 2'd3;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the reset vector, fetches the
// opcode and operand bytes, and hands complete instructions to execute.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// VEC_LO   | issue / capture reset vector low byte (vec_cap selects)
// VEC_HI   | issue / capture reset vector high byte, then load pc
// ISSUE_OP | read opcode byte, remember its address
// CAP_OP   | opcode on mem_data, decoder classifies length
// ISSUE_B1 | read first operand byte
// CAP_B1   | latch operand low byte
// ISSUE_B2 | read second operand byte
// CAP_B2   | latch operand high byte
// VALID    | instruction presented, waiting for out_ready
// JAM      | halted until reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_stall,
    output logic [7:0]  op,
    input  logic [4:0]  op_type,
    input  logic        single_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_op,
    output logic [15:0] out_opnd,
    output logic [1:0]  out_len,
    output logic [15:0] out_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        jam
);

    fetch_state_t state;
    logic         vec_cap;
    logic [15:0]  pc;
    logic [7:0]   op_q;
    logic [7:0]   lo_q;
    logic [7:0]   hi_q;
    logic [1:0]   len_q;
    logic [15:0]  out_pc_q;

    logic [1:0]   dec_len;
    logic         dec_jam;
    logic         is_issue;
    logic         can_redirect;
    logic         take_redirect;

    instr_len u_instr_len (
        .op_type     (op_type),
        .single_byte (single_byte),
        .len         (dec_len),
        .is_jam      (dec_jam)
    );

    // Classify the current state for read issue and redirect acceptance.
    always_comb begin
        is_issue     = 1'b0;
        can_redirect = 1'b0;
        case (state)
            VEC_LO, VEC_HI:             is_issue = ~vec_cap;
            ISSUE_OP, ISSUE_B1, ISSUE_B2: begin
                is_issue     = 1'b1;
                can_redirect = 1'b1;
            end
            CAP_OP, CAP_B1, CAP_B2, VALID: can_redirect = 1'b1;
            default: ;
        endcase
    end

    assign take_redirect = redirect & can_redirect;

    // A redirecting cycle issues nothing so no stale read is left in flight.
    assign mem_rd    = is_issue & ~mem_stall & ~take_redirect & ~rst;
    assign mem_addr  = mem_rd ? pc : 16'h0000;
    assign op        = (state == CAP_OP) ? mem_data : op_q;
    assign out_valid = (state == VALID) & ~rst;
    assign jam       = (state == JAM) & ~rst;
    assign out_op    = op_q;
    assign out_opnd  = {hi_q, lo_q};
    assign out_len   = len_q;
    assign out_pc    = out_pc_q;

    // Fetch FSM, program counter and instruction holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= VEC_LO;
            vec_cap  <= 1'b0;
            pc       <= RESET_VEC;
            op_q     <= 8'h00;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
            len_q    <= 2'd0;
            out_pc_q <= 16'h0000;
        end else if (take_redirect) begin
            state <= ISSUE_OP;
            pc    <= redirect_pc;
        end else begin
            case (state)
                VEC_LO: begin
                    if (!vec_cap) begin
                        if (!mem_stall) begin
                            pc      <= pc + 16'd1;
                            vec_cap <= 1'b1;
                        end
                    end else begin
                        lo_q    <= mem_data;
                        vec_cap <= 1'b0;
                        state   <= VEC_HI;
                    end
                end
                VEC_HI: begin
                    if (!vec_cap) begin
                        if (!mem_stall) begin
                            pc      <= pc + 16'd1;
                            vec_cap <= 1'b1;
                        end
                    end else begin
                        pc      <= {mem_data, lo_q};
                        vec_cap <= 1'b0;
                        state   <= ISSUE_OP;
                    end
                end
                ISSUE_OP: begin
                    if (!mem_stall) begin
                        out_pc_q <= pc;
                        pc       <= pc + 16'd1;
                        state    <= CAP_OP;
                    end
                end
                CAP_OP: begin
                    op_q <= mem_data;
                    lo_q <= 8'h00;
                    hi_q <= 8'h00;
                    if (dec_jam) begin
                        state <= JAM;
                    end else begin
                        len_q <= dec_len;
                        state <= (dec_len == 2'd1) ? VALID : ISSUE_B1;
                    end
                end
                ISSUE_B1: begin
                    if (!mem_stall) begin
                        pc    <= pc + 16'd1;
                        state <= CAP_B1;
                    end
                end
                CAP_B1: begin
                    lo_q  <= mem_data;
                    state <= (len_q == 2'd3) ? ISSUE_B2 : VALID;
                end
                ISSUE_B2: begin
                    if (!mem_stall) begin
                        pc    <= pc + 16'd1;
                        state <= CAP_B2;
                    end
                end
                CAP_B2: begin
                    hi_q  <= mem_data;
                    state <= VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        state <= ISSUE_OP;
                    end
                end
                JAM: ;
                default: state <= VEC_LO;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the opcode decoder.
- Owns the program counter and reads the reset vector after reset.
- Reads the opcode byte, drives it to the decoder, and uses the decoder's op_type/single_byte to work out instruction length (1–3 bytes).
- Reads the operand bytes, then presents the assembled instruction to the execute sequencer over a valid/ready handshake.

Parameters:
RESET_VEC, 16'hFFFC, address of the reset vector low byte (high byte at RESET_VEC+1)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_addr  out  16  read address
mem_rd  out  1  read strobe; data returns on mem_data the following cycle
mem_data  in  8  read data, valid the cycle after mem_rd
mem_stall  in  1  bus in use by execute; fetch must not assert mem_rd
op  out  8  opcode to decoder (mem_data in CAP_OP, else op_q)
op_type  in  5  from decoder
single_byte  in  1  from decoder
out_valid  out  1  instruction available
out_ready  in  1  execute accepts instruction
out_op  out  8  opcode
out_opnd  out  16  {hi,lo} operand bytes; unused bytes are 0
out_len  out  2  instruction length, 1..3
out_pc  out  16  address of the opcode byte
redirect  in  1  load new PC (branch/jump/interrupt), flush
redirect_pc  in  16  new PC
jam  out  1  JAM opcode fetched; core halted

Behaviour:
- Reset (async) values:
  - state=VEC_LO, pc=RESET_VEC.
  - All outputs 0 except op=op_q=8'h00.
  - Reset mid-read discards the returning data.
- States: VEC_LO, VEC_HI, ISSUE_OP, CAP_OP, ISSUE_B1, CAP_B1, ISSUE_B2, CAP_B2, VALID, JAM.
- Each byte uses an issue cycle (mem_rd=1, mem_addr=pc, pc<=pc+1) followed by a capture cycle (latch mem_data). At most one read is outstanding.
- Vector fetch:
  - VEC_LO issues RESET_VEC and captures the low byte; VEC_HI issues RESET_VEC+1.
  - pc is loaded from {hi,lo} in the capture cycle, then the unit goes to ISSUE_OP.
- ISSUE_OP: records out_pc<=pc, issues the read, goes to CAP_OP.
- CAP_OP: op=mem_data combinationally; op_q<=mem_data. Length decision:
  - op_type==OP_JAM → JAM.
  - single_byte | OP_RTI | OP_RTS → len 1, go VALID.
  - OP_JSR, OP_ABS, OP_JUM, OP_JIN, OP_AXY → len 3.
  - All others → len 2.
  - For len 2 or 3, go ISSUE_B1.
- CAP_B1: latch lo; len 3 → ISSUE_B2, else VALID. CAP_B2: latch hi, go VALID.
- Latency from ISSUE_OP to out_valid: 2 cycles (len 1), 4 cycles (len 2), 6 cycles (len 3).
- VALID:
  - out_* are stable while out_valid=1 and out_ready=0.
  - Transfer happens on out_valid&out_ready; the next cycle is ISSUE_OP with pc already at the next instruction.
- mem_stall: in any ISSUE/VEC issue cycle, mem_rd=0, state and pc hold. Has no effect on capture cycles.
- redirect, in any state except JAM and the vector states:
  - Next cycle is ISSUE_OP with pc=redirect_pc; out_valid=0.
  - An in-flight read's data is discarded.
  - redirect takes priority over a simultaneous transfer: the instruction counts as accepted and no refetch occurs.
  - redirect is ignored during VEC_LO/VEC_HI.
- JAM: jam=1, out_valid=0, mem_rd=0. Only rst exits; redirect is ignored.
- pc arithmetic is 16-bit and wraps (16'hFFFF+1 = 16'h0000), including across operand bytes.

Decomposition:
- op_type encodings (OP_*) stay in the shared 6502 defines header.
- Add a fetch_state_t enum and RESET_VEC default to the shared package.
- Length classification goes in one combinational sub-module, instr_len (inputs op_type, single_byte; outputs len[1:0], is_jam), reused by the execute sequencer for PC-relative maths.
- The FSM, pc and operand registers stay in fetch_unit.

Test Plan:
- Reset vector: memory [FFFC]=00, [FFFD]=80, out_ready=1. Expect reads at FFFC, FFFD, then 8000; out_pc=16'h8000.
- 1-byte instruction: [8000]=E8 (INX). Expect out_valid exactly 2 cycles after the 8000 read; out_len=1, out_opnd=0; next read at 8001.
- 3-byte instruction with backpressure: [8000..8002]=AD 34 12 (LDA abs), out_ready held 0 for 5 cycles. Expect out_opnd=16'h1234, out_len=3; outputs stable while stalled; no mem_rd; next read at 8003 only after ready.
- Redirect during operand fetch: [8000]=A9 (LDA #), redirect=1, redirect_pc=C000 asserted in CAP_OP+1. Expect the A9 instruction is never presented; next mem_rd at C000.
- mem_stall plus wrap: pc=FFFF, [FFFF]=A9, [0000]=55, mem_stall high 3 cycles at ISSUE_B1. Expect mem_rd=0 for 3 cycles, then a read at 0000; out_opnd=16'h0055, out_pc=FFFF.
- JAM: [8000]=02. Expect jam=1, out_valid=0, no further reads; redirect has no effect; rst restarts from the vector fetch.
